// File: rtl/ssd_pkg.sv
// ---------------------------------------------------------------------------
// ssd_pkg
// Shared definitions for the seven-segment scan driver slice.
//   - conv_state_e : converter FSM states (IDLE, SHIFT, COMMIT)
//   - BCD_SHIFTS   : number of double-dabble shifts per conversion
//   - SEG_0..SEG_9 : active-low cathode patterns {g,f,e,d,c,b,a}
//   - SEG_BLANK    : all segments off
//   - ANODE_OFF    : all digits disabled (anodes are active-low)
//   - segDecode    : nibble to cathode pattern
//   - dabbleAdjust : add-3 correction applied to every BCD nibble >= 5
// ---------------------------------------------------------------------------
package ssd_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } conv_state_e;

    localparam int BCD_SHIFTS = 13;
    localparam int SR_W       = 16 + BCD_SHIFTS;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [3:0] ANODE_OFF = 4'b1111;

    // Nibbles above 9 cannot come out of the converter; they fall back to
    // a dark digit rather than some random pattern.
    function automatic logic [6:0] segDecode(input logic [3:0] nibble);
        logic [6:0] seg;
        case (nibble)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

    // The BCD nibbles live in sr[28:13]; the binary bits below them are
    // left alone. A nibble of at most 9 plus 3 never overflows 4 bits.
    function automatic logic [SR_W-1:0] dabbleAdjust(input logic [SR_W-1:0] sr);
        logic [SR_W-1:0] adjusted;
        adjusted = sr;
        for (int i = 0; i < 4; i++) begin
            if (adjusted[BCD_SHIFTS + 4*i +: 4] >= 4'd5) begin
                adjusted[BCD_SHIFTS + 4*i +: 4] = adjusted[BCD_SHIFTS + 4*i +: 4] + 4'd3;
            end
        end
        return adjusted;
    endfunction

endpackage

// File: rtl/ssd_bin2bcd.sv
// ---------------------------------------------------------------------------
// ssd_bin2bcd
// Sequential double-dabble converter. A new conversion starts whenever the
// input differs from the last value captured; the result is committed only
// when all 13 shifts have completed.
// Ports:
//   clk   : system clock
//   rst   : asynchronous active-high reset
//   value : binary number, VALUE_W bits (1..13)
//   busy  : high from the capture edge until the commit edge
//   bcd   : last committed 4-digit BCD result, [3:0] = ones
// ---------------------------------------------------------------------------
module ssd_bin2bcd
    import ssd_pkg::*;
#(
    parameter int VALUE_W = 13
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [VALUE_W-1:0] value,
    output logic               busy,
    output logic [15:0]        bcd
);

    localparam logic [3:0] LAST_SHIFT = 4'(BCD_SHIFTS - 1);

    conv_state_e        state_q;
    logic [VALUE_W-1:0] lastValue_q;
    logic [SR_W-1:0]    sr_q;
    logic [3:0]         bitCnt_q;
    logic               busy_q;
    logic [15:0]        bcd_q;

    logic [BCD_SHIFTS-1:0] valueExt;
    logic [SR_W-1:0]       srShift_d;

    // Narrower inputs are zero-extended so the shift count stays fixed at 13
    // regardless of VALUE_W.
    assign valueExt  = BCD_SHIFTS'(value);
    assign srShift_d = dabbleAdjust(sr_q) << 1;

    // Converter FSM. Input changes while SHIFT/COMMIT are running are not
    // lost: the next IDLE cycle compares against lastValue_q and restarts.
    // busy and bcd are registered here so they never glitch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            lastValue_q <= '0;
            sr_q        <= '0;
            bitCnt_q    <= '0;
            busy_q      <= 1'b0;
            bcd_q       <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (value != lastValue_q) begin
                        lastValue_q <= value;
                        sr_q        <= {16'b0, valueExt};
                        bitCnt_q    <= '0;
                        busy_q      <= 1'b1;
                        state_q     <= SHIFT;
                    end
                end
                SHIFT: begin
                    sr_q     <= srShift_d;
                    bitCnt_q <= bitCnt_q + 4'd1;
                    if (bitCnt_q == LAST_SHIFT) begin
                        state_q <= COMMIT;
                    end
                end
                COMMIT: begin
                    bcd_q   <= sr_q[SR_W-1:BCD_SHIFTS];
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign bcd  = bcd_q;

endmodule

// File: rtl/ssd_scan_driver.sv
// ---------------------------------------------------------------------------
// ssd_scan_driver
// Display endpoint for the core's 13-bit debug value: converts it to BCD and
// time-multiplexes the four digits onto a common-anode seven-segment display.
// Ports:
//   clk     : system clock
//   rst     : asynchronous active-high reset
//   value   : binary number to display, may change at any cycle
//   busy    : conversion in progress
//   bcd     : last committed BCD result, [3:0] ones .. [15:12] thousands
//   anode   : active-low one-hot digit enable, bit0 = ones digit
//   cathode : active-low segments {g,f,e,d,c,b,a}
// Build option:
//   SSD_LEADING_ZERO_BLANK_EN : when defined, leading zero digits are dark
//                               (the ones digit is always lit).
// ---------------------------------------------------------------------------
module ssd_scan_driver
    import ssd_pkg::*;
#(
    parameter int VALUE_W         = 13,
    parameter int TICKS_PER_DIGIT = 100000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [VALUE_W-1:0] value,
    output logic               busy,
    output logic [15:0]        bcd,
    output logic [3:0]         anode,
    output logic [6:0]         cathode
);

    localparam int              TICK_W    = $clog2(TICKS_PER_DIGIT);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICKS_PER_DIGIT - 1);

    logic [15:0]       bcdValue;
    logic [TICK_W-1:0] tickCnt_q;
    logic [1:0]        digitIdx_q;
    logic [3:0]        anode_q;
    logic [6:0]        cathode_q;
    logic [3:0]        nibble;
    logic [3:0]        blankMask;

    ssd_bin2bcd #(
        .VALUE_W (VALUE_W)
    ) u_bin2bcd (
        .clk   (clk),
        .rst   (rst),
        .value (value),
        .busy  (busy),
        .bcd   (bcdValue)
    );

    assign nibble = bcdValue[{digitIdx_q, 2'b00} +: 4];

    // Marks digits that should stay dark. With blanking enabled a digit is
    // dark when it and every digit to its left are zero; the ones digit is
    // never blanked so a value of 0 still shows "0".
    always_comb begin
        blankMask = 4'b0000;
`ifdef SSD_LEADING_ZERO_BLANK_EN
        blankMask[3] = (bcdValue[15:12] == 4'd0);
        blankMask[2] = blankMask[3] && (bcdValue[11:8] == 4'd0);
        blankMask[1] = blankMask[2] && (bcdValue[7:4] == 4'd0);
`endif
    end

    // Digit scanner, free-running and independent of the converter. The
    // digit index wraps 3 -> 0 naturally through its 2-bit width.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tickCnt_q  <= '0;
            digitIdx_q <= '0;
        end else if (tickCnt_q == TICK_LAST) begin
            tickCnt_q  <= '0;
            digitIdx_q <= digitIdx_q + 2'd1;
        end else begin
            tickCnt_q <= tickCnt_q + TICK_W'(1);
        end
    end

    // Registered pin drivers, one cycle behind the digit index. A freshly
    // committed bcd therefore only reaches the pins on a register update,
    // never mid-cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            anode_q   <= ANODE_OFF;
            cathode_q <= SEG_BLANK;
        end else begin
            anode_q   <= ~(4'b0001 << digitIdx_q);
            cathode_q <= blankMask[digitIdx_q] ? SEG_BLANK : segDecode(nibble);
        end
    end

    assign bcd     = bcdValue;
    assign anode   = anode_q;
    assign cathode = cathode_q;

endmodule

// File: tb/tb_ssd_scan_driver.sv
// ---------------------------------------------------------------------------
// tb_ssd_scan_driver
// Directed self-checking bench for ssd_scan_driver with a short scan period
// (TICKS_PER_DIGIT = 4). Expected values are hand-computed constants.
// Honours SSD_LEADING_ZERO_BLANK_EN for the leading-digit expectations.
// ---------------------------------------------------------------------------
module tb_ssd_scan_driver;

    logic        clock;
    logic        reset;
    logic [12:0] value;
    logic        busy;
    logic [15:0] bcd;
    logic [3:0]  anode;
    logic [6:0]  cathode;

    int testsRun  = 0;
    int failCount = 0;

    ssd_scan_driver #(
        .VALUE_W         (13),
        .TICKS_PER_DIGIT (4)
    ) dut (
        .clk     (clock),
        .rst     (reset),
        .value   (value),
        .busy    (busy),
        .bcd     (bcd),
        .anode   (anode),
        .cathode (cathode)
    );

    // 10 ns clock, rising edges at 5, 15, 25, ...
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Hard stop in case something wedges the sequence.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired before the test sequence finished");
        $fatal(1, "[TB] watchdog");
    end

    // Drives a new input value on the falling edge so the next rising edge
    // sees it cleanly.
    task automatic applyStimulus(input logic [12:0] newValue);
        @(negedge clock);
        value = newValue;
    endtask

    // Waits for the capture edge and then for busy to drop, bounded.
    task automatic waitConversion();
        int n;
        @(posedge clock);
        #1;
        n = 0;
        while (busy && n < 60) begin
            @(posedge clock);
            #1;
            n++;
        end
        if (busy) begin
            testsRun++;
            failCount++;
            $display("[TB] FAIL conversion_timeout busy=%b required 0", busy);
        end
    endtask

    // Leaves the bench sampled on the first cycle that the ones digit is lit.
    task automatic alignToDigitZero();
        int n;
        n = 0;
        while (anode !== 4'b0111 && n < 40) begin
            @(posedge clock);
            #1;
            n++;
        end
        n = 0;
        while (anode !== 4'b1110 && n < 10) begin
            @(posedge clock);
            #1;
            n++;
        end
        if (anode !== 4'b1110) begin
            testsRun++;
            failCount++;
            $display("[TB] FAIL scan_align anode=%b required 1110", anode);
        end
    endtask

    task automatic test_reset();
        // Reset asserted since time 0.
        #2;
        testsRun++;
        if (anode !== 4'b1111) begin failCount++; $display("[TB] FAIL reset_anode got %b want 1111", anode); end
        testsRun++;
        if (cathode !== 7'b1111111) begin failCount++; $display("[TB] FAIL reset_cathode got %b want 1111111", cathode); end
        testsRun++;
        if (bcd !== 16'h0000) begin failCount++; $display("[TB] FAIL reset_bcd got %h want 0000", bcd); end
        testsRun++;
        if (busy !== 1'b0) begin failCount++; $display("[TB] FAIL reset_busy got %b want 0", busy); end

        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;
        testsRun++;
        if (anode !== 4'b1110) begin failCount++; $display("[TB] FAIL first_anode got %b want 1110", anode); end
        testsRun++;
        if (cathode !== 7'b1000000) begin failCount++; $display("[TB] FAIL first_cathode got %b want 1000000", cathode); end
        repeat (3) @(posedge clock);
        #1;
        testsRun++;
        if (busy !== 1'b0) begin failCount++; $display("[TB] FAIL zero_no_convert busy got %b want 0", busy); end

        // Asynchronous assertion between clock edges.
        @(negedge clock);
        #2;
        reset = 1'b1;
        #1;
        testsRun++;
        if (anode !== 4'b1111) begin failCount++; $display("[TB] FAIL async_reset_anode got %b want 1111", anode); end
        testsRun++;
        if (cathode !== 7'b1111111) begin failCount++; $display("[TB] FAIL async_reset_cathode got %b want 1111111", cathode); end
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_conversion();
        logic [12:0] vecValue [2];
        logic [15:0] vecBcd   [2];
        logic [15:0] oldBcd;
        vecValue[0] = 13'd8191; vecBcd[0] = 16'h8191;
        vecValue[1] = 13'd1234; vecBcd[1] = 16'h1234;
        oldBcd = 16'h0000;
        for (int v = 0; v < 2; v++) begin
            applyStimulus(vecValue[v]);
            @(posedge clock);
            #1;
            testsRun++;
            if (busy !== 1'b1) begin failCount++; $display("[TB] FAIL conv%0d_busy_capture got %b want 1", v, busy); end
            repeat (13) @(posedge clock);
            #1;
            testsRun++;
            if (busy !== 1'b1) begin failCount++; $display("[TB] FAIL conv%0d_busy_edge13 got %b want 1", v, busy); end
            testsRun++;
            if (bcd !== oldBcd) begin failCount++; $display("[TB] FAIL conv%0d_bcd_edge13 got %h want %h", v, bcd, oldBcd); end
            @(posedge clock);
            #1;
            testsRun++;
            if (bcd !== vecBcd[v]) begin failCount++; $display("[TB] FAIL conv%0d_bcd_edge14 got %h want %h", v, bcd, vecBcd[v]); end
            testsRun++;
            if (busy !== 1'b0) begin failCount++; $display("[TB] FAIL conv%0d_busy_edge14 got %b want 0", v, busy); end
            oldBcd = vecBcd[v];
        end
    endtask

    task automatic test_mid_change();
        logic [15:0] expBcd;
        logic        expBusy;
        applyStimulus(13'd0);
        waitConversion();
        testsRun++;
        if (bcd !== 16'h0000) begin failCount++; $display("[TB] FAIL mid_pre_bcd got %h want 0000", bcd); end

        applyStimulus(13'd1234);
        @(posedge clock);
        for (int i = 1; i <= 29; i++) begin
            @(posedge clock);
            #1;
            expBcd  = (i < 14) ? 16'h0000 : ((i < 29) ? 16'h1234 : 16'h5678);
            expBusy = (i < 14) || (i >= 15 && i < 29);
            testsRun++;
            if (bcd !== expBcd) begin failCount++; $display("[TB] FAIL mid_bcd_edge%0d got %h want %h", i, bcd, expBcd); end
            testsRun++;
            if (busy !== expBusy) begin failCount++; $display("[TB] FAIL mid_busy_edge%0d got %b want %b", i, busy, expBusy); end
            if (i == 5) begin
                @(negedge clock);
                value = 13'd5678;
            end
        end
    endtask

    task automatic test_scan();
        logic [6:0] expCath [4];
        logic [3:0] expAnode;
        int         digit;
        expCath[0] = 7'b0011001;
        expCath[1] = 7'b0110000;
        expCath[2] = 7'b0100100;
        expCath[3] = 7'b1111001;
        applyStimulus(13'd1234);
        waitConversion();
        testsRun++;
        if (bcd !== 16'h1234) begin failCount++; $display("[TB] FAIL scan_bcd got %h want 1234", bcd); end
        alignToDigitZero();
        for (int k = 0; k < 20; k++) begin
            if (k > 0) begin
                @(posedge clock);
                #1;
            end
            digit = (k / 4) % 4;
            expAnode = ~(4'b0001 << digit);
            testsRun++;
            if (anode !== expAnode) begin failCount++; $display("[TB] FAIL scan_anode_cycle%0d got %b want %b", k, anode, expAnode); end
            testsRun++;
            if (cathode !== expCath[digit]) begin failCount++; $display("[TB] FAIL scan_cathode_cycle%0d got %b want %b", k, cathode, expCath[digit]); end
        end
    endtask

    task automatic test_reset_during_shift();
        applyStimulus(13'd999);
        @(posedge clock);
        repeat (7) @(posedge clock);
        #3;
        reset = 1'b1;
        #1;
        testsRun++;
        if (bcd !== 16'h0000) begin failCount++; $display("[TB] FAIL shift_reset_bcd got %h want 0000", bcd); end
        testsRun++;
        if (busy !== 1'b0) begin failCount++; $display("[TB] FAIL shift_reset_busy got %b want 0", busy); end
        value = 13'd0;
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clock);
            #1;
            testsRun++;
            if (busy !== 1'b0) begin failCount++; $display("[TB] FAIL post_reset_idle_cycle%0d busy got %b want 0", i, busy); end
        end
        testsRun++;
        if (bcd !== 16'h0000) begin failCount++; $display("[TB] FAIL post_reset_bcd got %h want 0000", bcd); end
        applyStimulus(13'd999);
        waitConversion();
        testsRun++;
        if (bcd !== 16'h0999) begin failCount++; $display("[TB] FAIL post_reset_999 got %h want 0999", bcd); end
    endtask

    task automatic test_leading_digits();
        logic [12:0] vecValue [2];
        logic [15:0] vecBcd   [2];
        logic [6:0]  expCath  [2][4];
        vecValue[0] = 13'd42; vecBcd[0] = 16'h0042;
        vecValue[1] = 13'd0;  vecBcd[1] = 16'h0000;
`ifdef SSD_LEADING_ZERO_BLANK_EN
        expCath[0][0] = 7'b0100100; expCath[0][1] = 7'b0011001;
        expCath[0][2] = 7'b1111111; expCath[0][3] = 7'b1111111;
        expCath[1][0] = 7'b1000000; expCath[1][1] = 7'b1111111;
        expCath[1][2] = 7'b1111111; expCath[1][3] = 7'b1111111;
`else
        expCath[0][0] = 7'b0100100; expCath[0][1] = 7'b0011001;
        expCath[0][2] = 7'b1000000; expCath[0][3] = 7'b1000000;
        expCath[1][0] = 7'b1000000; expCath[1][1] = 7'b1000000;
        expCath[1][2] = 7'b1000000; expCath[1][3] = 7'b1000000;
`endif
        for (int v = 0; v < 2; v++) begin
            applyStimulus(vecValue[v]);
            waitConversion();
            testsRun++;
            if (bcd !== vecBcd[v]) begin failCount++; $display("[TB] FAIL lead%0d_bcd got %h want %h", v, bcd, vecBcd[v]); end
            alignToDigitZero();
            for (int k = 0; k < 16; k++) begin
                if (k > 0) begin
                    @(posedge clock);
                    #1;
                end
                testsRun++;
                if (cathode !== expCath[v][k/4]) begin
                    failCount++;
                    $display("[TB] FAIL lead%0d_cathode_cycle%0d got %b want %b", v, k, cathode, expCath[v][k/4]);
                end
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        value = 13'd0;
        test_reset();
        test_conversion();
        test_mid_change();
        test_scan();
        test_reset_during_shift();
        test_leading_digits();
        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
